intr_ctrl_core: RTL and testbench
=================================

INTR_CTRL_CORE -- requirements
Module: intr_ctrl_core

Interface
REQ-001 Parameter N_SRC, default 8, number of interrupt sources (1..16).
REQ-002 clk  input  1  system clock, all state rising-edge triggered.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cs  input  1  slot select from MMIO bus.
REQ-005 read  input  1  bus read strobe; no read side effects.
REQ-006 write  input  1  bus write strobe; a write occurs when write & cs.
REQ-007 reg_addr  input  5  word register address within slot.
REQ-008 wr_data  input  32  write data.
REQ-009 rd_data  output  32  read data, combinational from reg_addr.
REQ-010 irq_src  input  N_SRC  source requests (e.g. timer counter_done), synchronous to clk.
REQ-011 irq_out  output  1  registered interrupt request to CPU, active-high.

Function
REQ-012 Register map: 0 CTRL (bit0 global enable, RW); 1 ENABLE (RW, bits N_SRC-1:0); 2 TYPE (RW, 1=rising-edge, 0=level); 3 PENDING (read; write-1-to-clear edge bits); 4 RAW (RO, registered irq_src); 5 ACTIVE_ID (RO, bit31 valid, bits 3:0 index); all other addresses SHALL read 0 and ignore writes.
REQ-013 irq_src SHALL be sampled every cycle into src_q; rising edge = irq_src & ~src_q.
REQ-014 Edge-type pending bit SHALL set on the clock edge where a rising edge is detected, independent of ENABLE.
REQ-015 Level-type pending bit SHALL equal src_q each cycle; W1C has no effect on it.
REQ-016 W1C write to PENDING SHALL clear each edge-type bit whose wr_data bit is 1 on that clock edge.
REQ-017 Simultaneous edge-set and W1C on the same bit SHALL leave the bit set (set wins).
REQ-018 Changing TYPE from edge to level SHALL make the bit follow src_q from the next cycle; level to edge SHALL clear it.
REQ-019 active = PENDING & ENABLE; ACTIVE_ID SHALL report the lowest-index set bit of active, bit31=1; if none, read 0.
REQ-020 irq_out SHALL be registered: at each clock edge irq_out <= CTRL.bit0 & |active.
REQ-021 Latency: edge source rising in cycle n SHALL set PENDING at edge n+1 and irq_out at edge n+2.
REQ-022 Writing ENABLE or CTRL SHALL affect irq_out at the edge after the write edge.
REQ-023 Source held high SHALL produce exactly one edge-type pending set until it falls and rises again.
REQ-024 rd_data upper bits beyond N_SRC for ENABLE/TYPE/PENDING/RAW SHALL read 0.

Reset
REQ-025 On reset: CTRL=0, ENABLE=0, TYPE=all 1s (edge), PENDING=0, src_q=0, irq_out=0.
REQ-026 Reset asserted mid-operation SHALL clear all pending state immediately; a source high at reset release SHALL register an edge on the first clock edge after release.

Structure
REQ-027 Shared package intr_pkg SHALL hold register address constants (CTRL..ACTIVE_ID), default N_SRC, and the ACTIVE_ID valid-bit position.
REQ-028 One sub-module irq_edge_det (per-source sampling register plus rising-edge pulse) SHALL be instantiated N_SRC times via generate.

Verification
REQ-029 CTRL=1, ENABLE=0x01, TYPE=0x01; irq_src[0] 0->1 at cycle 10 -> PENDING=0x01 after edge 11, irq_out=1 after edge 12, ACTIVE_ID=0x80000000.
REQ-030 irq_src[0] held high 20 cycles, W1C PENDING=0x01 at cycle 15 -> PENDING=0, irq_out=0 two edges later, no re-set while high.
REQ-031 Write PENDING W1C 0x01 in same cycle as new src[0] rising edge -> PENDING bit0 remains 1, irq_out stays 1.
REQ-032 TYPE=0x00, ENABLE=0x06, src[2] high then src[1] high -> ACTIVE_ID=0x80000001; drop src[1] -> 0x80000002; drop src[2] -> irq_out=0.
REQ-033 Pending bit 3 set with ENABLE=0 -> irq_out=0; write ENABLE=0x08 -> irq_out=1 next edge; CTRL=0 -> irq_out=0 next edge.
REQ-034 Assert reset while PENDING=0xFF and irq_out=1 -> all registers at reset values same cycle; read addr 7 -> 0.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared constants for the interrupt controller slice.
//   - register word addresses inside the MMIO slot
//   - default number of interrupt sources
//   - ACTIVE_ID field layout
package intr_pkg;

  localparam int N_SRC_DEFAULT = 8;

  localparam logic [4:0] ADDR_CTRL      = 5'd0;
  localparam logic [4:0] ADDR_ENABLE    = 5'd1;
  localparam logic [4:0] ADDR_TYPE      = 5'd2;
  localparam logic [4:0] ADDR_PENDING   = 5'd3;
  localparam logic [4:0] ADDR_RAW       = 5'd4;
  localparam logic [4:0] ADDR_ACTIVE_ID = 5'd5;

  localparam int ACTIVE_VALID_BIT = 31;
  localparam int ACTIVE_ID_W      = 4;

endpackage

// File: rtl/intr_ctrl_core_if.sv
// MMIO slot bus between the CPU-side decoder (master) and the interrupt
// controller register block (slave).
//   cs, read, write, reg_addr, wr_data : master -> slave
//   rd_data                            : slave -> master (combinational)
interface intr_ctrl_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, reg_addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, reg_addr, wr_data, output rd_data);
endinterface

// File: rtl/irq_edge_det.sv
// Per-source sampler: registers the request every cycle and flags a rising
// edge when the live input is high and the previous sample was low.
//   clk, reset : clock, async active-high reset
//   src        : live source request
//   src_q      : registered source (RAW / level pending value)
//   rise       : combinational rising-edge pulse
module irq_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic src_q,
  output logic rise
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) src_q <= 1'b0;
    else       src_q <= src;
  end

  // src_q clears on reset, so a source already high at release
  // registers an edge on the first clock after release.
  assign rise = src & ~src_q;

endmodule

// File: rtl/intr_ctrl_core.sv
// Interrupt controller core: per-source edge/level pending capture, enable
// masking, lowest-index priority encode and a registered CPU interrupt.
//   clk, reset : clock, async active-high reset
//   bus        : MMIO slot (slave side), rd_data combinational on reg_addr
//   irq_src    : N_SRC source requests, synchronous to clk
//   irq_out    : registered interrupt request to the CPU
module intr_ctrl_core
  import intr_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  intr_ctrl_core_if.slave  bus,
  input  logic [N_SRC-1:0] irq_src,
  output logic             irq_out
);

  logic             ctrl_en;
  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] type_q;     // 1 = rising edge, 0 = level
  logic [N_SRC-1:0] pend_edge;  // latched edge events, only meaningful where type_q=1
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] w1c;
  logic             wr_en;
  logic [ACTIVE_ID_W-1:0] act_id;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    irq_edge_det u_det (
      .clk   (clk),
      .reset (reset),
      .src   (irq_src[i]),
      .src_q (src_q[i]),
      .rise  (rise[i])
    );
  end

  assign wr_en = bus.write & bus.cs;
  assign w1c   = (wr_en && bus.reg_addr == ADDR_PENDING) ? bus.wr_data[N_SRC-1:0] : '0;

  // Level bits mirror the sampled source; edge bits come from the latch.
  // Masking pend_edge by type_q hides stale edge state the cycle after an
  // edge->level switch.
  assign pending = (type_q & pend_edge) | (~type_q & src_q);
  assign active  = pending & enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      enable    <= '0;
      type_q    <= '1;
      pend_edge <= '0;
      irq_out   <= 1'b0;
    end else begin
      if (wr_en && bus.reg_addr == ADDR_CTRL)   ctrl_en <= bus.wr_data[0];
      if (wr_en && bus.reg_addr == ADDR_ENABLE) enable  <= bus.wr_data[N_SRC-1:0];
      if (wr_en && bus.reg_addr == ADDR_TYPE)   type_q  <= bus.wr_data[N_SRC-1:0];
      // Set beats clear; level bits hold 0 so a level->edge switch starts clean.
      pend_edge <= type_q & (rise | (pend_edge & ~w1c));
      irq_out   <= ctrl_en & (|active);
    end
  end

  // Lowest-index active source wins: scan high to low so the last hit sticks.
  always_comb begin
    act_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) act_id = i[ACTIVE_ID_W-1:0];
    end
  end

  always_comb begin
    bus.rd_data = '0;
    case (bus.reg_addr)
      ADDR_CTRL:      bus.rd_data[0]         = ctrl_en;
      ADDR_ENABLE:    bus.rd_data[N_SRC-1:0] = enable;
      ADDR_TYPE:      bus.rd_data[N_SRC-1:0] = type_q;
      ADDR_PENDING:   bus.rd_data[N_SRC-1:0] = pending;
      ADDR_RAW:       bus.rd_data[N_SRC-1:0] = src_q;
      ADDR_ACTIVE_ID: begin
        if (|active) begin
          bus.rd_data[ACTIVE_VALID_BIT]  = 1'b1;
          bus.rd_data[ACTIVE_ID_W-1:0]   = act_id;
        end
      end
      default:        bus.rd_data = '0;
    endcase
  end

  // Reads have no side effects and upper write-data bits have no home.
  logic unused_bus;
  assign unused_bus = ^{bus.read, bus.wr_data[31:N_SRC]};

endmodule

// File: tb/tb_intr_ctrl_core.sv
module tb_intr_ctrl_core;
  import intr_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irq_src = '0;
  logic       irq_out;
  int         n_chk = 0;
  int         n_fail = 0;

  intr_ctrl_core_if bus ();

  intr_ctrl_core #(.N_SRC(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .irq_src (irq_src),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    bus.reg_addr = a;
    #1;
    chk(tag, bus.rd_data, exp);
  endtask

  task automatic irq(input logic exp, input string tag);
    chk(tag, {31'd0, irq_out}, {31'd0, exp});
  endtask

  // Drives a write at the current negedge; it lands on the next posedge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.reg_addr = a; bus.wr_data = d;
    tick();
    bus.cs = 1'b0; bus.write = 1'b0; bus.wr_data = '0;
  endtask

  initial begin
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.reg_addr = '0; bus.wr_data = '0;
    tick(); tick();

    // reset values
    rd(ADDR_CTRL, 32'h0, "rst_ctrl");
    rd(ADDR_ENABLE, 32'h0, "rst_enable");
    rd(ADDR_TYPE, 32'hFF, "rst_type");
    rd(ADDR_PENDING, 32'h0, "rst_pending");
    rd(ADDR_ACTIVE_ID, 32'h0, "rst_active_id");
    irq(1'b0, "rst_irq");
    reset = 1'b0;
    tick();

    // basic edge path and latency
    wr(ADDR_CTRL, 32'h1);
    wr(ADDR_ENABLE, 32'h1);
    wr(ADDR_TYPE, 32'h1);
    irq_src[0] = 1'b1;
    rd(ADDR_PENDING, 32'h0, "edge_pend_before");
    tick();
    rd(ADDR_PENDING, 32'h1, "edge_pend_n1");
    irq(1'b0, "edge_irq_n1");
    tick();
    irq(1'b1, "edge_irq_n2");
    rd(ADDR_ACTIVE_ID, 32'h8000_0000, "edge_active_id");
    rd(ADDR_RAW, 32'h1, "edge_raw");

    // held high, W1C clears, no re-set
    tick(); tick();
    wr(ADDR_PENDING, 32'h1);
    rd(ADDR_PENDING, 32'h0, "w1c_pend_cleared");
    irq(1'b1, "w1c_irq_lag");
    tick();
    irq(1'b0, "w1c_irq_low");
    tick(); tick(); tick();
    rd(ADDR_PENDING, 32'h0, "held_no_reset");

    // set wins over simultaneous clear
    irq_src[0] = 1'b0;
    tick();
    irq_src[0] = 1'b1;
    wr(ADDR_PENDING, 32'h1);
    rd(ADDR_PENDING, 32'h1, "setwins_pend");
    tick();
    irq(1'b1, "setwins_irq");
    tick();
    irq(1'b1, "setwins_irq_hold");
    wr(ADDR_PENDING, 32'h1);
    irq_src[0] = 1'b0;
    tick(); tick();
    irq(1'b0, "cleanup_irq");

    // level sources and priority
    wr(ADDR_TYPE, 32'h0);
    wr(ADDR_ENABLE, 32'h6);
    irq_src[2] = 1'b1;
    tick();
    rd(ADDR_PENDING, 32'h4, "lvl_pend_src2");
    rd(ADDR_ACTIVE_ID, 32'h8000_0002, "lvl_id_src2");
    wr(ADDR_PENDING, 32'h4);
    rd(ADDR_PENDING, 32'h4, "lvl_w1c_ignored");
    irq(1'b1, "lvl_irq");
    irq_src[1] = 1'b1;
    tick();
    rd(ADDR_ACTIVE_ID, 32'h8000_0001, "lvl_id_src1");
    irq_src[1] = 1'b0;
    tick();
    rd(ADDR_ACTIVE_ID, 32'h8000_0002, "lvl_id_back2");
    irq_src[2] = 1'b0;
    tick();
    rd(ADDR_ACTIVE_ID, 32'h0, "lvl_id_none");
    irq(1'b1, "lvl_irq_lag");
    tick();
    irq(1'b0, "lvl_irq_low");

    // level -> edge switch clears the bit
    irq_src[3] = 1'b1;
    tick();
    rd(ADDR_PENDING, 32'h8, "sw_lvl_pend");
    wr(ADDR_TYPE, 32'h8);
    rd(ADDR_PENDING, 32'h0, "sw_edge_cleared");
    irq_src[3] = 1'b0;
    tick();

    // enable / ctrl gating
    wr(ADDR_ENABLE, 32'h0);
    irq_src[3] = 1'b1;
    tick();
    rd(ADDR_PENDING, 32'h8, "gate_pend3");
    tick();
    irq(1'b0, "gate_irq_masked");
    wr(ADDR_ENABLE, 32'h8);
    irq(1'b0, "gate_en_lag");
    tick();
    irq(1'b1, "gate_en_irq");
    wr(ADDR_CTRL, 32'h0);
    irq(1'b1, "gate_ctrl_lag");
    tick();
    irq(1'b0, "gate_ctrl_off");
    irq_src[3] = 1'b0;

    // upper bits read 0, unmapped addresses
    wr(ADDR_ENABLE, 32'hFFFF_FFFF);
    rd(ADDR_ENABLE, 32'hFF, "upper_bits_zero");
    wr(5'd7, 32'hFFFF_FFFF);
    rd(5'd7, 32'h0, "unmapped_rd");
    rd(ADDR_CTRL, 32'h0, "unmapped_no_alias");

    // reset mid-operation
    wr(ADDR_TYPE, 32'hFF);
    wr(ADDR_CTRL, 32'h1);
    irq_src = 8'hFF;
    tick();
    rd(ADDR_PENDING, 32'hFF, "pre_rst_pend");
    tick();
    irq(1'b1, "pre_rst_irq");
    reset = 1'b1;
    rd(ADDR_PENDING, 32'h0, "mid_rst_pend");
    irq(1'b0, "mid_rst_irq");
    rd(ADDR_CTRL, 32'h0, "mid_rst_ctrl");
    rd(ADDR_ENABLE, 32'h0, "mid_rst_enable");
    rd(ADDR_TYPE, 32'hFF, "mid_rst_type");
    rd(ADDR_RAW, 32'h0, "mid_rst_raw");
    rd(5'd7, 32'h0, "mid_rst_addr7");
    tick();
    reset = 1'b0;
    tick();
    rd(ADDR_PENDING, 32'hFF, "post_rst_edge");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
